// File: rtl/data_cache_writeback_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package    : data_cache_pkg
//  Description: Field-enable and packet types shared by a data cache way and
//               the units that access it.
//  Revision   : 1.0 - initial release
// ============================================================================
package data_cache_pkg;
    localparam int c_tag_size  = 20;
    localparam int c_word_size = 32;

    // One enable bit per field of a cache way entry
    typedef struct packed {
        logic valid;
        logic dirty;
        logic tag;
        logic data;
    } data_cache_enable_t;

    // One cache way entry as seen through a port: status, tag and one block word
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [c_tag_size-1:0]  tag;
        logic [c_word_size-1:0] word;
    } data_cache_packet_t;
endpackage

// ============================================================================
//  Module     : data_cache_writeback_unit
//  Description: Evicts one line of a data cache way. Looks up status/tag on
//               way port 1; a valid and dirty line has each block word read
//               and streamed to memory over a valid/ready handshake, after
//               which the dirty bit is cleared through way port 0.
//  Revision   : 1.0 - initial release
//
//  Ports
//    clk_i, rst_i          clock (rising edge), async active-high reset
//    start_i, index_i      writeback request and line index (IDLE only)
//    busy_o                high in every state except IDLE
//    done_o, written_o     end-of-operation pulse, line-was-written flag
//    port1_*               read-only way port (status/tag lookup, word reads)
//    port0_*               R/W way port (dirty-bit clear)
//    mem_*                 write beat stream {tag, index, word, 2'b00} / data
// ============================================================================
module data_cache_writeback_unit
    import data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int CHIP_ADDR  = 3,
    parameter int TAG_SIZE   = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] index_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  written_o,
    output logic                  port1_read_o,
    output data_cache_enable_t    port1_enable_o,
    output logic [ADDR_WIDTH-1:0] port1_address_o,
    output logic [CHIP_ADDR-1:0]  port1_chip_select_o,
    input  data_cache_packet_t    port1_packet_i,
    output logic                  port0_write_o,
    output data_cache_enable_t    port0_enable_o,
    output logic [ADDR_WIDTH-1:0] port0_address_o,
    output data_cache_packet_t    port0_packet_o,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [31:0]           mem_address_o,
    output logic [31:0]           mem_data_o
);

    generate
        if ((TAG_SIZE + ADDR_WIDTH + CHIP_ADDR + 2 != 32) || (TAG_SIZE != c_tag_size)) begin : g_param_check
            $error("data_cache_writeback_unit: TAG_SIZE+ADDR_WIDTH+CHIP_ADDR+2 must be 32 and TAG_SIZE must match the packet tag");
        end
    endgenerate

    localparam logic [CHIP_ADDR-1:0] c_last_word = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_CHECK  = 3'd2,
        S_READ   = 3'd3,
        S_SEND   = 3'd4,
        S_CLEAR  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ADDR_WIDTH-1:0]   r_index;
    logic [TAG_SIZE-1:0]     r_tag;
    logic [CHIP_ADDR-1:0]    r_counter;
    logic [31:0]             r_data;
    logic                    r_send_first;
    logic                    r_written;
    logic                    w_line_dirty;

    assign w_line_dirty = port1_packet_i.valid & port1_packet_i.dirty;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        busy_o              = (r_state != S_IDLE);
        done_o              = 1'b0;
        written_o           = 1'b0;
        port1_read_o        = 1'b0;
        port1_enable_o      = '0;
        port1_address_o     = '0;
        port1_chip_select_o = '0;
        port0_write_o       = 1'b0;
        port0_enable_o      = '0;
        port0_address_o     = '0;
        port0_packet_o      = '0;
        mem_valid_o         = 1'b0;
        mem_address_o       = '0;
        mem_data_o          = '0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                port1_read_o         = 1'b1;
                port1_enable_o.valid = 1'b1;
                port1_enable_o.dirty = 1'b1;
                port1_enable_o.tag   = 1'b1;
                port1_address_o      = r_index;
                w_state_next         = S_CHECK;
            end
            S_CHECK: begin
                w_state_next = w_line_dirty ? S_READ : S_DONE;
            end
            S_READ: begin
                port1_read_o        = 1'b1;
                port1_enable_o.data = 1'b1;
                port1_address_o     = r_index;
                port1_chip_select_o = r_counter;
                w_state_next        = S_SEND;
            end
            S_SEND: begin
                mem_valid_o   = 1'b1;
                mem_address_o = {r_tag, r_index, r_counter, 2'b00};
                // The word arrives from the way during the first SEND cycle;
                // forward it then and hold the captured copy while stalled.
                mem_data_o    = r_send_first ? port1_packet_i.word : r_data;
                if (mem_ready_i) begin
                    w_state_next = (r_counter == c_last_word) ? S_CLEAR : S_READ;
                end
            end
            S_CLEAR: begin
                port0_write_o        = 1'b1;
                port0_enable_o.dirty = 1'b1;
                port0_address_o      = r_index;
                port0_packet_o.valid = 1'b1;
                port0_packet_o.dirty = 1'b0;
                w_state_next         = S_DONE;
            end
            S_DONE: begin
                done_o       = 1'b1;
                written_o    = r_written;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_index      <= '0;
            r_tag        <= '0;
            r_counter    <= '0;
            r_data       <= '0;
            r_send_first <= 1'b0;
            r_written    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_index <= index_i;
                    end
                end
                S_CHECK: begin
                    r_written <= 1'b0;
                    if (w_line_dirty) begin
                        r_tag     <= port1_packet_i.tag;
                        r_counter <= '0;
                    end
                end
                S_READ: begin
                    r_send_first <= 1'b1;
                end
                S_SEND: begin
                    if (r_send_first) begin
                        r_data       <= port1_packet_i.word;
                        r_send_first <= 1'b0;
                    end
                    if (mem_ready_i && (r_counter != c_last_word)) begin
                        r_counter <= r_counter + 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_written <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache_writeback_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module     : tb_data_cache_writeback_unit
//  Description: Self-checking bench for data_cache_writeback_unit. Models a
//               cache way (synchronous read port 1, write port 0) and a memory
//               sink with controllable ready; expected beats, latencies and
//               dirty-bit updates come from the line contents.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_data_cache_writeback_unit;
    import data_cache_pkg::*;

    localparam int c_lines = 128;
    localparam int c_words = 8;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               start_i;
    logic [6:0]         index_i;
    logic               busy_o, done_o, written_o;
    logic               port1_read_o;
    data_cache_enable_t port1_enable_o;
    logic [6:0]         port1_address_o;
    logic [2:0]         port1_chip_select_o;
    data_cache_packet_t port1_packet_i;
    logic               port0_write_o;
    data_cache_enable_t port0_enable_o;
    logic [6:0]         port0_address_o;
    data_cache_packet_t port0_packet_o;
    logic               mem_valid_o;
    logic               mem_ready_i;
    logic [31:0]        mem_address_o, mem_data_o;

    data_cache_writeback_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .index_i(index_i),
        .busy_o(busy_o), .done_o(done_o), .written_o(written_o),
        .port1_read_o(port1_read_o), .port1_enable_o(port1_enable_o),
        .port1_address_o(port1_address_o), .port1_chip_select_o(port1_chip_select_o),
        .port1_packet_i(port1_packet_i),
        .port0_write_o(port0_write_o), .port0_enable_o(port0_enable_o),
        .port0_address_o(port0_address_o), .port0_packet_o(port0_packet_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_address_o(mem_address_o), .mem_data_o(mem_data_o)
    );

    always #5 clk_i = ~clk_i;

    // Way contents
    bit          m_valid [c_lines];
    bit          m_dirty [c_lines];
    logic [19:0] m_tag   [c_lines];
    logic [31:0] m_word  [c_lines][c_words];

    // Monitor state
    int          n_checks = 0, n_pass = 0;
    int          beats_cnt = 0, p0_cnt = 0, p0_bad = 0, p1_bad = 0;
    int          done_cnt = 0, stall_cnt = 0, stab_err = 0;
    int          stall_beat = -1, stall_left = 0, cur_idx = 0;
    bit          rand_ready = 0;
    logic [31:0] beat_addr[$];
    logic [31:0] beat_data[$];
    bit          prev_valid = 0, prev_ready = 1;
    logic [31:0] prev_addr, prev_data;
    bit          rd_pend = 0;
    int          rd_addr = 0, rd_cs = 0;
    data_cache_enable_t rd_en;
    data_cache_packet_t rd_pk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Way port 1: synchronous read, data for disabled fields is garbage
    always @(posedge clk_i) begin
        rd_pk.valid = 1'($urandom);
        rd_pk.dirty = 1'($urandom);
        rd_pk.tag   = 20'($urandom);
        rd_pk.word  = $urandom;
        if (rd_pend) begin
            if (rd_en.valid) rd_pk.valid = m_valid[rd_addr];
            if (rd_en.dirty) rd_pk.dirty = m_dirty[rd_addr];
            if (rd_en.tag)   rd_pk.tag   = m_tag[rd_addr];
            if (rd_en.data)  rd_pk.word  = m_word[rd_addr][rd_cs];
        end
        port1_packet_i <= rd_pk;
    end

    // Mid-cycle observation of the DUT and ready generation
    always @(negedge clk_i) begin
        if (prev_valid && !prev_ready) begin
            if (!mem_valid_o || mem_address_o !== prev_addr || mem_data_o !== prev_data) stab_err++;
        end
        if (mem_valid_o && beats_cnt == stall_beat && stall_left > 0) begin
            mem_ready_i = 1'b0;
            stall_left--;
        end else if (rand_ready && mem_valid_o) begin
            mem_ready_i = ($urandom_range(0, 2) != 0);
        end else begin
            mem_ready_i = 1'b1;
        end
        if (mem_valid_o) begin
            if (mem_ready_i) begin
                beat_addr.push_back(mem_address_o);
                beat_data.push_back(mem_data_o);
                beats_cnt++;
            end else begin
                stall_cnt++;
            end
        end
        prev_valid = mem_valid_o;
        prev_ready = mem_ready_i;
        prev_addr  = mem_address_o;
        prev_data  = mem_data_o;
        if (done_o) done_cnt++;
        if (port0_write_o) begin
            p0_cnt++;
            if (port0_enable_o !== 4'b0100 || port0_address_o !== 7'(cur_idx) ||
                port0_packet_o.dirty !== 1'b0 || port0_packet_o.valid !== 1'b1) p0_bad++;
            if (port0_enable_o.dirty) m_dirty[port0_address_o] = port0_packet_o.dirty;
            if (port0_enable_o.valid) m_valid[port0_address_o] = port0_packet_o.valid;
        end
        rd_pend = port1_read_o;
        if (port1_read_o) begin
            if (port1_address_o !== 7'(cur_idx) ||
                (port1_enable_o !== 4'b1110 && port1_enable_o !== 4'b0001)) p1_bad++;
            rd_addr = int'(port1_address_o);
            rd_cs   = int'(port1_chip_select_o);
            rd_en   = port1_enable_o;
        end
    end

    task automatic load_line(input int idx, input bit v, input bit d, input logic [19:0] t,
                             input logic [31:0] base, input bit rnd);
        m_valid[idx] = v;
        m_dirty[idx] = d;
        m_tag[idx]   = t;
        for (int i = 0; i < c_words; i++) m_word[idx][i] = rnd ? $urandom : base + 32'(i);
    endtask

    task automatic clear_monitors(input int idx, input int s_beat, input int s_len, input bit rnd_rdy);
        beat_addr.delete();
        beat_data.delete();
        beats_cnt = 0; p0_cnt = 0; p0_bad = 0; p1_bad = 0;
        done_cnt = 0; stall_cnt = 0; stab_err = 0;
        stall_beat = s_beat; stall_left = s_len; rand_ready = rnd_rdy; cur_idx = idx;
    endtask

    // One full operation on line idx; expectations derived from the line image
    task automatic run_op(input int idx, input int s_beat, input int s_len, input int inj,
                          input bit rnd_rdy, input bit exp_w, input int exp_lat, input string nm);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        bit old_dirty, seen, wr, injected;
        int cyc, lat;
        old_dirty = m_dirty[idx];
        if (m_valid[idx] && m_dirty[idx]) begin
            for (int i = 0; i < c_words; i++) begin
                ea.push_back({m_tag[idx], 7'(idx), 3'(i), 2'b00});
                ed.push_back(m_word[idx][i]);
            end
        end
        clear_monitors(idx, s_beat, s_len, rnd_rdy);
        index_i = 7'(idx);
        start_i = 1'b1;
        cyc = 0; seen = 0; wr = 0; injected = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk_i); #1;
            cyc++;
            start_i = 1'b0;
            if (done_o) begin
                seen = 1;
                wr   = written_o;
            end else if (inj >= 0 && !injected && mem_valid_o && beats_cnt == inj + 1) begin
                start_i  = 1'b1;
                index_i  = 7'(idx) ^ 7'h2A;
                injected = 1;
            end
        end
        lat = exp_lat + (rnd_rdy ? stall_cnt : 0);
        check({nm, " done_seen"}, 64'(seen), 64'd1);
        check({nm, " latency"}, 64'(cyc), 64'(lat));
        if (exp_w && !rnd_rdy && s_len > 0) check({nm, " stall_cycles"}, 64'(stall_cnt), 64'(s_len));
        check({nm, " written"}, 64'(wr), 64'(exp_w));
        check({nm, " beat_count"}, 64'(beats_cnt), 64'(ea.size()));
        if (beats_cnt == ea.size()) begin
            for (int i = 0; i < ea.size(); i++)
                check($sformatf("%s beat%0d", nm, i), {beat_addr[i], beat_data[i]}, {ea[i], ed[i]});
        end
        check({nm, " port0_writes"}, 64'(p0_cnt), 64'(exp_w));
        check({nm, " port0_fields"}, 64'(p0_bad), 64'd0);
        check({nm, " port1_fields"}, 64'(p1_bad), 64'd0);
        check({nm, " stall_stable"}, 64'(stab_err), 64'd0);
        check({nm, " dirty_after"}, 64'(m_dirty[idx]), exp_w ? 64'd0 : 64'(old_dirty));
        repeat (4) @(negedge clk_i);
        #1;
        check({nm, " single_done"}, 64'(done_cnt), 64'd1);
        check({nm, " idle_after"}, 64'(busy_o), 64'd0);
        index_i = '0;
    endtask

    function automatic logic any_output();
        return |{busy_o, done_o, written_o, port1_read_o, port1_enable_o, port1_address_o,
                 port1_chip_select_o, port0_write_o, port0_enable_o, port0_address_o,
                 port0_packet_o, mem_valid_o, mem_address_o, mem_data_o};
    endfunction

    typedef struct {
        bit          v;
        bit          d;
        logic [19:0] tag;
        int          idx;
        logic [31:0] base;
        int          s_beat;
        int          s_len;
        int          inj;
        bit          exp_w;
        int          exp_lat;
        string       nm;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 0, 20'h12345, 5,    32'h0,        -1, 0, -1, 0, 3,  "clean"};
        vecs[1] = '{0, 1, 20'h54321, 6,    32'h0,        -1, 0, -1, 0, 3,  "invalid_dirty"};
        vecs[2] = '{1, 1, 20'hABCDE, 8'h12, 32'h100,     -1, 0, -1, 1, 20, "dirty"};
        vecs[3] = '{1, 1, 20'hABCDE, 8'h12, 32'h100,      4, 3, -1, 1, 23, "dirty_stall"};
        vecs[4] = '{1, 1, 20'h00F0F, 8'h40, 32'hDEAD0000, -1, 0,  2, 1, 20, "start_in_send"};
        vecs[5] = '{0, 0, 20'h0,     0,    32'h0,        -1, 0, -1, 0, 3,  "invalid_clean"};
        vecs[6] = '{1, 1, 20'hFFFFF, 8'h7F, 32'hFFFFFFF8, 0, 1, -1, 1, 21, "top_index_stall0"};
        vecs[7] = '{1, 1, 20'h00001, 1,    32'h55,        7, 2, -1, 1, 22, "last_beat_stall"};

        for (int i = 0; i < c_lines; i++) load_line(i, 0, 0, 20'h0, 32'h0, 0);
        rst_i = 1'b1; start_i = 1'b0; index_i = '0; mem_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("reset_outputs", 64'(any_output()), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        check("idle_after_reset", 64'(any_output()), 64'd0);

        for (int k = 0; k < 8; k++) begin
            load_line(vecs[k].idx, vecs[k].v, vecs[k].d, vecs[k].tag, vecs[k].base, 0);
            run_op(vecs[k].idx, vecs[k].s_beat, vecs[k].s_len, vecs[k].inj, 0,
                   vecs[k].exp_w, vecs[k].exp_lat, vecs[k].nm);
        end

        // Reset during the fifth beat aborts without a clear or done pulse
        begin
            int guard;
            load_line(8'h21, 1, 1, 20'h13579, 32'h900, 0);
            clear_monitors(8'h21, -1, 0, 0);
            index_i = 7'h21;
            start_i = 1'b1;
            guard = 0;
            @(negedge clk_i); #1;
            start_i = 1'b0;
            while (!(beats_cnt >= 5 && mem_valid_o) && guard < 100) begin
                @(negedge clk_i); #1;
                guard++;
            end
            check("abort reached_beat5", 64'(guard < 100), 64'd1);
            #2 rst_i = 1'b1;
            #1;
            check("abort outputs_zero", 64'(any_output()), 64'd0);
            repeat (2) @(negedge clk_i);
            rst_i = 1'b0;
            repeat (2) @(negedge clk_i);
            #1;
            check("abort no_port0", 64'(p0_cnt), 64'd0);
            check("abort no_done", 64'(done_cnt), 64'd0);
            check("abort dirty_kept", 64'(m_dirty[8'h21]), 64'd1);
            run_op(8'h21, -1, 0, -1, 0, 1, 20, "after_abort");
        end

        // Random lines against random memory back-pressure
        for (int r = 0; r < 24; r++) begin
            int idx;
            bit v, d;
            idx = $urandom_range(0, c_lines - 1);
            v = 1'($urandom);
            d = 1'($urandom);
            load_line(idx, v, d, 20'($urandom), 32'h0, 1);
            run_op(idx, -1, 0, -1, 1, v & d, (v & d) ? 20 : 3, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
